// File: rtl/note_sequencer.sv
// note_sequencer
//
// Plays a list of note codes held in an external synchronous-read note memory.
// A sequence starts from IDLE on `start`. Each note is fetched, wait one cycle
// for the memory data, offered downstream, and then held for a number of beats.
// After the last note the sequence either restarts at address 0 (loop_en) or
// pulses `done` and returns to IDLE. `stop` aborts at any time without `done`.
//
// Optional build macro:
//   NOTE_SEQ_REST_SKIP_EN - a fetched note code of 0 is treated as a rest.
//                           It is never offered downstream and is not held.
//                           The sequence advances straight from WAIT.
//
// Ports:
//   clk          in   single clock, all logic on posedge
//   reset        in   synchronous, active-high
//   start        in   begin a sequence (sampled only in IDLE)
//   stop         in   abort the sequence (priority over start)
//   num_notes    in   [ADDR_W:0]   notes to play, 0..2**ADDR_W
//   beat_cycles  in   [BEAT_W-1:0] clocks a note is held after acceptance
//   loop_en      in   restart at address 0 after the last note
//   mem_rd_addr  out  [ADDR_W-1:0] note memory read address (= idx)
//   mem_rd_data  in   [NOTE_W-1:0] note memory data, one cycle after address
//   note_out     out  [NOTE_W-1:0] current note code
//   note_valid   out  note_out offered downstream
//   note_ready   in   downstream accepts note
//   note_start   out  handshake pulse
//   busy         out  high when not IDLE
//   done         out  one-cycle pulse on normal completion
//
// Handshake: note_valid is high only in PRESENT. While it is high, note_out
// does not change. The note is accepted in the cycle where note_valid and
// note_ready are both high at the clock edge. note_start marks that cycle.
module note_sequencer #(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 8,
  parameter int BEAT_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   num_notes,
  input  logic [BEAT_W-1:0] beat_cycles,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [NOTE_W-1:0] mem_rd_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  input  logic              note_ready,
  output logic              note_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};

  state_t              state, state_n;
  // idx is one bit wider than the address so that the last-note compare
  // against num_notes-1 works for a full 2**ADDR_W note list.
  logic [ADDR_W:0]     idx, idx_n;
  logic [ADDR_W:0]     num_lat, num_n;
  logic [BEAT_W-1:0]   beat_lat, beat_n;
  logic                loop_lat, loop_n;
  logic [BEAT_W-1:0]   cnt, cnt_n;
  logic [NOTE_W-1:0]   note_q, note_n;
  logic                done_q, done_n;

  // Result of the "next note" rule, shared by HOLD and the rest-skip path.
  state_t              adv_state;
  logic [ADDR_W:0]     adv_idx;
  logic                adv_done;
  logic [BEAT_W-1:0]   beat_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      num_lat  <= '0;
      beat_lat <= '0;
      loop_lat <= 1'b0;
      cnt      <= '0;
      note_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      num_lat  <= num_n;
      beat_lat <= beat_n;
      loop_lat <= loop_n;
      cnt      <= cnt_n;
      note_q   <= note_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    adv_state = FETCH;
    adv_idx   = idx;
    adv_done  = 1'b0;
    if (idx < num_lat - IDX_ONE) begin
      adv_idx = idx + IDX_ONE;
    end else if (loop_lat) begin
      adv_idx = '0;
    end else begin
      adv_state = IDLE;
      adv_done  = 1'b1;
    end
  end

  // The hold length is max(beat_cycles,1). The counter counts down to 0.
  assign beat_load = (beat_lat == '0) ? '0 : (beat_lat - BEAT_ONE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    num_n   = num_lat;
    beat_n  = beat_lat;
    loop_n  = loop_lat;
    cnt_n   = cnt;
    note_n  = note_q;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (num_notes != '0) begin
            num_n   = num_notes;
            beat_n  = beat_cycles;
            loop_n  = loop_en;
            idx_n   = '0;
            state_n = FETCH;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      FETCH: begin
        state_n = WAIT;
      end
      WAIT: begin
`ifdef NOTE_SEQ_REST_SKIP_EN
        if (mem_rd_data == '0) begin
          state_n = adv_state;
          idx_n   = adv_idx;
          done_n  = adv_done;
        end else begin
          note_n  = mem_rd_data;
          state_n = PRESENT;
        end
`else
        note_n  = mem_rd_data;
        state_n = PRESENT;
`endif
      end
      PRESENT: begin
        if (note_ready) begin
          cnt_n   = beat_load;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = adv_state;
          idx_n   = adv_idx;
          done_n  = adv_done;
        end else begin
          cnt_n = cnt - BEAT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // An abort overrides any transition, including a completing advance.
    if (stop && (state != IDLE)) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  assign mem_rd_addr = idx[ADDR_W-1:0];
  assign note_out    = note_q;
  assign note_valid  = (state == PRESENT);
  assign note_start  = note_valid & note_ready;
  assign busy        = (state != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer. A reference model expands each started
// sequence into the list of notes that must be handshaken. For each note it
// also gives the required cycle gap, not counting stall cycles, since the
// previous event. A negedge monitor pops and checks these entries.
// It also counts done pulses.
// Build with NOTE_SEQ_REST_SKIP_EN defined to check the rest-skip build.
module tb_note_sequencer;
  localparam int ADDR_W = 4;
  localparam int NOTE_W = 8;
  localparam int BEAT_W = 24;
`ifdef NOTE_SEQ_REST_SKIP_EN
  localparam bit REST_SKIP = 1'b1;
`else
  localparam bit REST_SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic [ADDR_W:0]   num_notes;
  logic [BEAT_W-1:0] beat_cycles;
  logic              loop_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [NOTE_W-1:0] mem_rd_data;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              note_ready;
  logic              note_start;
  logic              busy;
  logic              done;

  logic [NOTE_W-1:0] mem [16];
  logic [NOTE_W-1:0] exp_q[$];
  int                gap_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  note_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .num_notes(num_notes), .beat_cycles(beat_cycles), .loop_en(loop_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .note_out(note_out), .note_valid(note_valid), .note_ready(note_ready),
    .note_start(note_start), .busy(busy), .done(done)
  );

  // ---------------- clock / memory / ready ----------------
  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  initial begin
    note_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       note_ready = 1'b1;
        1:       note_ready = ($urandom_range(0, 3) != 0);
        default: note_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Walks the note list as the player should. Rests are skipped in the
  // rest-skip build, and each skipped rest costs two cycles. It returns the
  // number of handshakes it queued.
  function automatic int push_expect(input int n, input int beat, input bit lp,
                                     input int max_hs);
    int h, extra, pushed, pos, visits;
    bit first;
    h = (beat == 0) ? 1 : beat;
    extra = 0; pushed = 0; pos = 0; visits = 0; first = 1'b1;
    while (pushed < max_hs && visits < 64) begin
      if (pos == n) begin
        if (!lp) break;
        pos = 0;
      end
      if (REST_SKIP && mem[pos] == '0) begin
        extra += 2;
      end else begin
        exp_q.push_back(mem[pos]);
        gap_q.push_back((first ? 3 : h + 3) + extra);
        extra = 0;
        first = 1'b0;
        pushed++;
      end
      pos++;
      visits++;
    end
    return pushed;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int since = 0;
  int stalls = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      since = 0;
      stalls = 0;
      prev_done = 1'b0;
    end else begin
      if (start && !stop && !busy && num_notes != '0) begin
        since = 0;
        stalls = 0;
      end else begin
        since++;
      end
      checks++;
      if (note_start !== (note_valid & note_ready)) begin
        errors++;
        $display("FAIL note_start actual=%b required=%b", note_start, note_valid & note_ready);
      end
      if (note_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_note actual=%0h required=no_note", note_out);
        end else begin
          if (note_out !== exp_q[0]) begin
            errors++;
            $display("FAIL note_out actual=%0h required=%0h", note_out, exp_q[0]);
          end
          if (note_ready) begin
            checks++;
            if ((since - stalls) != gap_q[0]) begin
              errors++;
              $display("FAIL note_gap actual=%0d required=%0d", since - stalls, gap_q[0]);
            end
            void'(exp_q.pop_front());
            void'(gap_q.pop_front());
            hs_cnt++;
            since = 0;
            stalls = 0;
          end else begin
            stalls++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (busy || prev_done) begin
          errors++;
          $display("FAIL done_pulse actual=busy%b_prev%b required=busy0_prev0", busy, prev_done);
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input int b, input bit l);
    cyc();
    num_notes = n[ADDR_W:0];
    beat_cycles = b[BEAT_W-1:0];
    loop_en = l;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Waits for busy to fall. With churn it also keeps changing the
  // configuration inputs and issues starts while the sequence is busy.
  task automatic wait_idle(input bit churn);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!busy) break;
      if (churn) begin
        start = $urandom_range(0, 1) != 0;
        num_notes = $urandom_range(0, 16);
        beat_cycles = $urandom_range(0, 9);
        loop_en = $urandom_range(0, 1) != 0;
      end
      cyc();
      if (!busy) start = 1'b0;
    end
    start = 1'b0;
    loop_en = 1'b0;
    if (k >= 3000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_once(input int n, input int b, input bit churn);
    int d0;
    d0 = done_cnt;
    void'(push_expect(n, b, 1'b0, 1000));
    do_start(n, b, 1'b0);
    wait_idle(churn);
    @(negedge clk);
    #1;
    chk("done_count", done_cnt - d0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run_loop(input int n, input int b, input int k_hs);
    int d0, h0, c, k;
    d0 = done_cnt;
    h0 = hs_cnt;
    c = push_expect(n, b, 1'b1, k_hs);
    do_start(n, b, 1'b1);
    if (c == 0) begin
      repeat (12) cyc();
      chk("rest_loop_busy", busy, 32'd1);
    end else begin
      for (k = 0; k < 2000 && hs_cnt < h0 + c; k++) begin
        @(negedge clk);
        #1;
      end
      chk("loop_hs_count", hs_cnt - h0, c);
    end
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_busy", busy, 32'd0);
    chk("stop_valid", note_valid, 32'd0);
    repeat (3) cyc();
    chk("stop_no_done", done_cnt - d0, 32'd0);
    chk("loop_queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic load_mem3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    mem[0] = a;
    mem[1] = b;
    mem[2] = c;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, h0, n, b;
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_notes = '0;
    beat_cycles = '0; loop_en = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) cyc();
    chk("rst_busy", busy, 32'd0);
    chk("rst_valid", note_valid, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_note_out", note_out, 32'd0);
    chk("rst_addr", mem_rd_addr, 32'd0);
    reset = 1'b0;
    cyc();

    // Normal run: three notes, beat 4, always ready.
    load_mem3(8'h3C, 8'h3E, 8'h40);
    ready_mode = 0;
    run_once(3, 4, 1'b0);

    // Backpressure on note 0 for 10 cycles.
    ready_mode = 2;
    void'(push_expect(3, 4, 1'b0, 1000));
    do_start(3, 4, 1'b0);
    repeat (2) cyc();
    chk("bp_valid_first", note_valid, 32'd1);
    chk("bp_note_first", note_out, 32'h3C);
    repeat (9) cyc();
    chk("bp_valid_last", note_valid, 32'd1);
    chk("bp_note_last", note_out, 32'h3C);
    cyc();
    ready_mode = 0;
    wait_idle(1'b0);
    @(negedge clk);
    #1;
    chk("bp_queue_drained", exp_q.size(), 32'd0);

    // Full depth with loop, beat 0, then stop.
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + i[7:0];
    run_loop(16, 0, 20);

    // Start with zero notes.
    d0 = done_cnt;
    cyc();
    num_notes = '0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_done", done, 32'd1);
    chk("zero_busy", busy, 32'd0);
    cyc();
    chk("zero_done_clear", done, 32'd0);
    chk("zero_busy_after", busy, 32'd0);

    // Start and stop together.
    d0 = done_cnt;
    cyc();
    num_notes = 5'd3;
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", busy, 32'd0);
    repeat (4) cyc();
    chk("startstop_busy_later", busy, 32'd0);
    chk("startstop_no_done", done_cnt - d0, 32'd0);

    // Reset during HOLD of note 2, then replay from address 0.
    load_mem3(8'h3C, 8'h3E, 8'h40);
    d0 = done_cnt;
    h0 = hs_cnt;
    void'(push_expect(3, 4, 1'b0, 1000));
    do_start(3, 4, 1'b0);
    for (int k = 0; k < 200 && hs_cnt < h0 + 3; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_mid_hs", hs_cnt - h0, 32'd3);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rstmid_busy", busy, 32'd0);
    chk("rstmid_valid", note_valid, 32'd0);
    chk("rstmid_done", done, 32'd0);
    chk("rstmid_note_out", note_out, 32'd0);
    chk("rstmid_addr", mem_rd_addr, 32'd0);
    chk("rstmid_no_done", done_cnt - d0, 32'd0);
    exp_q.delete();
    gap_q.delete();
    run_once(3, 4, 1'b0);

    // Rest in the middle of the list.
    load_mem3(8'h3C, 8'h00, 8'h40);
    run_once(3, 2, 1'b0);

    // All-rest looping sequence must still stop.
    for (int i = 0; i < 16; i++) mem[i] = '0;
    run_loop(4, 1, 3);

    // Randomized runs with backpressure and configuration churn.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      n = (r == 0) ? 16 : $urandom_range(1, 16);
      b = $urandom_range(0, 5);
      ready_mode = 1;
      run_once(n, b, 1'b1);
    end
    ready_mode = 0;

    repeat (4) cyc();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
- REQ-001: Parameters SHALL be, one per line as name, default, meaning:
  - ADDR_W, 4, note-memory address width (16 entries).
  - NOTE_W, 8, note-code width.
  - BEAT_W, 24, beat-length counter width.
- REQ-002: Ports SHALL be, one per line as name, direction, width, meaning:
  - clk, in, 1, single clock; all logic on posedge.
  - reset, in, 1, synchronous, active-high.
  - start, in, 1, begin a sequence (sampled only in IDLE).
  - stop, in, 1, abort the sequence.
  - num_notes, in, ADDR_W+1, notes to play, 0..16.
  - beat_cycles, in, BEAT_W, clocks per note after acceptance.
  - loop_en, in, 1, restart at address 0 after the last note.
  - mem_rd_addr, out, ADDR_W, note-memory read address.
  - mem_rd_data, in, NOTE_W, note-memory data, valid 1 cycle after address.
  - note_out, out, NOTE_W, current note code.
  - note_valid, out, 1, note_out valid.
  - note_ready, in, 1, downstream accepts note.
  - note_start, out, 1, handshake pulse (note_valid & note_ready).
  - busy, out, 1, high when not IDLE.
  - done, out, 1, one-cycle pulse on normal completion.

Function
- REQ-003: The FSM states SHALL be IDLE, FETCH, WAIT, PRESENT, HOLD; busy = (state != IDLE).
- REQ-004: IDLE: start=1 and num_notes!=0 SHALL latch num_notes, beat_cycles, loop_en, set idx=0, and go to FETCH; start with num_notes=0 SHALL stay IDLE and pulse done next cycle.
- REQ-005: Only the values latched at start SHALL be used; later changes to num_notes, beat_cycles and loop_en SHALL be ignored until the next start.
- REQ-006: mem_rd_addr SHALL equal registered idx at all times; FETCH SHALL last exactly 1 cycle, then go to WAIT.
- REQ-007: WAIT SHALL register mem_rd_data into note_out at its closing edge and go to PRESENT, giving start-to-note_valid latency of exactly 3 cycles.
- REQ-008: PRESENT SHALL hold note_valid=1 and note_out stable until note_ready=1 is sampled, then go to HOLD and load the beat counter with max(beat_cycles,1)-1.
- REQ-009: note_valid SHALL be 0 in every state except PRESENT; note_out SHALL retain its last value outside PRESENT.
- REQ-010: HOLD SHALL last exactly max(beat_cycles,1) cycles, then advance.
- REQ-011: Advance rule:
  - if idx < latched_num-1: idx+1, go to FETCH.
  - else if loop_en: idx=0, go to FETCH.
  - else: pulse done for 1 cycle, go to IDLE.
- REQ-012: idx arithmetic SHALL be ADDR_W+1 wide so that num_notes=16 reaches idx=15 without wrap aliasing.
- REQ-013: stop=1 in any non-IDLE state SHALL go to IDLE at the next edge, drop note_valid, and not pulse done.
- REQ-014: stop and start asserted together SHALL leave the block IDLE, with stop taking priority.
- REQ-015: start while busy SHALL be ignored.

Reset
- REQ-016: reset SHALL force IDLE, idx=0, beat counter=0, note_out=0, note_valid=0, done=0, busy=0, mem_rd_addr=0 at the next edge, overriding all other inputs.
- REQ-017: reset mid-sequence SHALL abort without a done pulse; the first start after reset release SHALL be honoured.

Configuration
- REQ-018: With NOTE_SEQ_REST_SKIP_EN defined, a fetched note code of 0 (rest) in WAIT SHALL skip PRESENT and HOLD and apply the REQ-011 advance rule directly; note_start and note_valid stay 0 for that entry.
- REQ-019: Without NOTE_SEQ_REST_SKIP_EN, code 0 SHALL be presented and held like any other note.
- REQ-020: In both builds, stop SHALL terminate an all-rest looping sequence per REQ-013.

Verification
- REQ-021: Normal run: memory = {0x3C,0x3E,0x40}, num_notes=3, beat_cycles=4, ready tied 1 -> note_valid at cycle start+3; notes 0x3C, 0x3E, 0x40 spaced 7 cycles apart; single done pulse; busy drops.
- REQ-022: Backpressure: note_ready held 0 for 10 cycles on note 0 -> note_valid and note_out stable for 10 cycles; HOLD starts only after acceptance.
- REQ-023: Full depth with loop: num_notes=16, loop_en=1, beat_cycles=0 -> addresses 0..15, then 0 again, each held 1 cycle; no done; stop -> IDLE next cycle with no done.
- REQ-024: Edge cases:
  - num_notes=0 with start -> done pulse, busy never set.
  - start and stop asserted together -> remains IDLE.
  - start while busy -> no effect.
- REQ-025: Reset asserted in HOLD of note 2 -> all outputs 0 next cycle, no done; new start replays from address 0.
- REQ-026: NOTE_SEQ_REST_SKIP_EN build: memory = {0x3C,0x00,0x40} -> only 0x3C and 0x40 handshaken; without the macro, 0x00 is also presented.
